// File: rtl/fwd_pkg.sv
// Shared types for the forwarding scoreboard: tag-table entry layout and stage indices.
package fwd_pkg;

    // Register tags are stored zero-extended to a fixed width so one struct serves every REG_NUM.
    localparam int TAG_W_MAX = 8;

    localparam int STG_EX = 0;
    localparam int STG_MM = 1;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] rd;
        logic                 is_load;
    } tag_entry_t;

    function automatic tag_entry_t mk_entry(input logic                 valid,
                                            input logic [TAG_W_MAX-1:0] rd,
                                            input logic                 is_load);
        tag_entry_t e;
        e.valid   = valid;
        e.rd      = rd;
        e.is_load = is_load;
        return e;
    endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Bundle of issue, stage-result, operand and forwarding signals around fwd_scoreboard.
// stall_cycles exists only when FWD_PERF_CNT_EN is defined.
interface fwd_scoreboard_if #(
    parameter int DATA_WIDTH   = 64,
    parameter int REG_NUM      = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int PIPE_DEPTH   = 3
) ();
    localparam int RW = $clog2(REG_NUM);

    logic                                      advance;
    logic                                      flush;
    logic                                      issue_valid;
    logic                                      issue_wr_en;
    logic                                      issue_is_load;
    logic [RW-1:0]                             issue_rd;
    logic [PIPE_DEPTH-1:0][DATA_WIDTH-1:0]     stage_data;
    logic [PIPE_DEPTH-1:0]                     stage_ready;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]   rf_data;
    logic [NUM_RD_PORTS-1:0][RW-1:0]           rs;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]   fwd_data;
    logic                                      stall;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]                               stall_cycles;
`endif

    modport master (
        output advance, flush, issue_valid, issue_wr_en, issue_is_load, issue_rd,
        output stage_data, stage_ready, rf_data, rs,
        input  fwd_data, stall
`ifdef FWD_PERF_CNT_EN
        , input stall_cycles
`endif
    );

    modport slave (
        input  advance, flush, issue_valid, issue_wr_en, issue_is_load, issue_rd,
        input  stage_data, stage_ready, rf_data, rs,
        output fwd_data, stall
`ifdef FWD_PERF_CNT_EN
        , output stall_cycles
`endif
    );

endinterface

// File: rtl/fwd_port_sel.sv
// One read port's forwarding mux: youngest matching in-flight entry wins, otherwise the
// register-file value; flags a hazard when that youngest match is not yet final.
module fwd_port_sel
    import fwd_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int RW         = 5,
    parameter int PIPE_DEPTH = 3
) (
    input  logic [RW-1:0]                         i_rs,
    input  tag_entry_t [PIPE_DEPTH-1:0]           i_tags,
    input  logic [PIPE_DEPTH-1:0][DATA_WIDTH-1:0] i_stage_data,
    input  logic [PIPE_DEPTH-1:0]                 i_stage_ready,
    input  logic [DATA_WIDTH-1:0]                 i_rf_data,
    output logic [DATA_WIDTH-1:0]                 o_fwd_data,
    output logic                                  o_hazard
);
    logic [TAG_W_MAX-1:0]  w_rs_ext;
    logic                  w_hit;
    logic                  w_sel_ready;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [PIPE_DEPTH-1:0] w_load_bits;
    logic                  w_unused_load;

    assign w_rs_ext = TAG_W_MAX'(i_rs);

    // Scan oldest to youngest so the youngest match overwrites; an older ready match can
    // never mask a younger pending one.
    always_comb begin
        w_hit       = 1'b0;
        w_sel_ready = 1'b1;
        w_sel_data  = i_rf_data;
        for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
            if (i_tags[i].valid && (i_tags[i].rd == w_rs_ext)) begin
                w_hit       = 1'b1;
                w_sel_ready = i_stage_ready[i];
                w_sel_data  = i_stage_data[i];
            end
        end
        if (i_rs == '0) begin
            w_hit       = 1'b0;
            w_sel_ready = 1'b1;
            w_sel_data  = i_rf_data;
        end
    end

    assign o_fwd_data = w_sel_data;
    assign o_hazard   = w_hit & ~w_sel_ready;

    // Readiness comes from stage_ready alone; the load flag is carried for observability only.
    for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_load
        assign w_load_bits[gi] = i_tags[gi].is_load;
    end
    assign w_unused_load = ^w_load_bits;

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding scoreboard: in-flight destination tag table plus per-port bypass select.
// Define FWD_PERF_CNT_EN to add the saturating stall_cycles counter.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int REG_NUM      = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int PIPE_DEPTH   = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    fwd_scoreboard_if.slave bus
);
    localparam int RW = $clog2(REG_NUM);

    tag_entry_t [PIPE_DEPTH-1:0]             r_tags;
    tag_entry_t                              w_new_entry;
    logic [NUM_RD_PORTS-1:0]                 w_port_hazard;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] w_fwd_data;
    logic                                    w_stall;

    // A stalled or flushed issue enters the pipe as a bubble; r0 writes are never tracked.
    assign w_new_entry = mk_entry(bus.issue_valid & bus.issue_wr_en & (bus.issue_rd != '0)
                                  & ~w_stall & ~bus.flush,
                                  TAG_W_MAX'(bus.issue_rd), bus.issue_is_load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tags <= '0;
        end else if (bus.advance) begin
            for (int i = STG_MM; i < PIPE_DEPTH; i++) begin
                r_tags[i] <= r_tags[i-1];
            end
            r_tags[STG_EX] <= w_new_entry;
        end else if (bus.flush) begin
            r_tags[STG_EX].valid <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_port
        fwd_port_sel #(
            .DATA_WIDTH (DATA_WIDTH),
            .RW         (RW),
            .PIPE_DEPTH (PIPE_DEPTH)
        ) u_sel (
            .i_rs          (bus.rs[gi]),
            .i_tags        (r_tags),
            .i_stage_data  (bus.stage_data),
            .i_stage_ready (bus.stage_ready),
            .i_rf_data     (bus.rf_data[gi]),
            .o_fwd_data    (w_fwd_data[gi]),
            .o_hazard      (w_port_hazard[gi])
        );
    end

    assign w_stall      = |w_port_hazard;
    assign bus.stall    = w_stall;
    assign bus.fwd_data = w_fwd_data;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: stimulus queues expected outputs, a negedge monitor
// pops and compares them. Counter checks are active when FWD_PERF_CNT_EN is defined.
module tb_fwd_scoreboard;
    localparam int DW = 64;
    localparam int RN = 32;
    localparam int NP = 2;
    localparam int PD = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fwd_scoreboard_if #(.DATA_WIDTH(DW), .REG_NUM(RN), .NUM_RD_PORTS(NP), .PIPE_DEPTH(PD)) bus ();

    fwd_scoreboard #(.DATA_WIDTH(DW), .REG_NUM(RN), .NUM_RD_PORTS(NP), .PIPE_DEPTH(PD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string         name;
        int            cyc;
        logic          stall;
        logic [1:0]    chk;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        bit            chk_cnt;
        logic [31:0]   cnt;
    } exp_t;

    exp_t sb_q[$];

    task automatic sb_push(input string name, input logic stall, input logic [1:0] chk,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        exp_t e;
        e.name = name; e.cyc = cyc; e.stall = stall; e.chk = chk;
        e.d0 = d0; e.d1 = d1; e.chk_cnt = 1'b0; e.cnt = '0;
        sb_q.push_back(e);
    endtask

    task automatic sb_push_cnt(input string name, input logic stall, input logic [31:0] cnt);
        exp_t e;
        e.name = name; e.cyc = cyc; e.stall = stall; e.chk = 2'b00;
        e.d0 = '0; e.d1 = '0; e.chk_cnt = 1'b1; e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    // Monitor: everything queued for this cycle is compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                n_tests++;
                if (e.cyc < cyc) begin
                    n_fail++;
                    $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
                end else begin
                    if (bus.stall !== e.stall) begin
                        n_fail++;
                        $display("FAIL %s.stall: got %b want %b", e.name, bus.stall, e.stall);
                    end
                    if (e.chk[0]) begin
                        n_tests++;
                        if (bus.fwd_data[0] !== e.d0) begin
                            n_fail++;
                            $display("FAIL %s.fwd0: got %h want %h", e.name, bus.fwd_data[0], e.d0);
                        end
                    end
                    if (e.chk[1]) begin
                        n_tests++;
                        if (bus.fwd_data[1] !== e.d1) begin
                            n_fail++;
                            $display("FAIL %s.fwd1: got %h want %h", e.name, bus.fwd_data[1], e.d1);
                        end
                    end
`ifdef FWD_PERF_CNT_EN
                    if (e.chk_cnt) begin
                        n_tests++;
                        if (bus.stall_cycles !== e.cnt) begin
                            n_fail++;
                            $display("FAIL %s.stall_cycles: got %0d want %0d", e.name, bus.stall_cycles, e.cnt);
                        end
                    end
`endif
                    $display("[TB] cyc %0d %s stall=%b fwd0=%h fwd1=%h", cyc, e.name, bus.stall,
                             bus.fwd_data[0], bus.fwd_data[1]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic wr_en, input logic is_load);
        bus.issue_valid   = 1'b1;
        bus.issue_wr_en   = wr_en;
        bus.issue_rd      = rd;
        bus.issue_is_load = is_load;
        bus.advance       = 1'b1;
    endtask

    task automatic hold();
        bus.issue_valid = 1'b0;
        bus.advance     = 1'b0;
    endtask

    task automatic drain();
        bus.rs[0] = '0; bus.rs[1] = '0;
        bus.issue_valid = 1'b0;
        bus.advance     = 1'b1;
        repeat (PD) tick();
        bus.advance = 1'b0;
    endtask

    initial begin
        bus.advance = 0; bus.flush = 0; bus.issue_valid = 0; bus.issue_wr_en = 0;
        bus.issue_is_load = 0; bus.issue_rd = '0; bus.stage_data = '0; bus.stage_ready = '0;
        bus.rf_data[0] = 64'h55; bus.rf_data[1] = 64'h66; bus.rs[0] = 5'd5; bus.rs[1] = '0;

        tick();
        sb_push("rst_hold", 1'b0, 2'b11, 64'h55, 64'h66);
`ifdef FWD_PERF_CNT_EN
        sb_push_cnt("cnt_rst", 1'b0, 32'd0);
`endif
        rst_n = 1'b1;
        bus.rs[0] = '0;
        tick();

        // ALU result forwarded from EX
        issue(5'd5, 1'b1, 1'b0);
        tick();
        hold();
        bus.rs[0] = 5'd5; bus.stage_data[0] = 64'hAA; bus.stage_ready = 3'b001;
        sb_push("alu_fwd", 1'b0, 2'b11, 64'hAA, 64'h66);
        tick();
        bus.stage_ready = 3'b000;
        sb_push("alu_notready", 1'b1, 2'b10, '0, 64'h66);
        tick();
        bus.stage_ready = 3'b001; bus.rs[0] = 5'd6;
        sb_push("rs_miss", 1'b0, 2'b11, 64'h55, 64'h66);
        tick();
        drain();

        // Load-use stall, stall+advance bubble, then forward from MM
        issue(5'd7, 1'b1, 1'b1);
        tick();
        hold();
        bus.rs[1] = 5'd7; bus.stage_ready = 3'b000;
        sb_push("load_stall", 1'b1, 2'b01, 64'h55, '0);
        tick();
        issue(5'd9, 1'b1, 1'b0);
        sb_push("stall_adv", 1'b1, 2'b01, 64'h55, '0);
        tick();
        hold();
        bus.rs[0] = 5'd9; bus.stage_data[0] = 64'hBAD; bus.stage_data[1] = 64'h1234;
        bus.stage_ready = 3'b010;
        sb_push("load_done", 1'b0, 2'b11, 64'h55, 64'h1234);
        tick();
        bus.stage_ready = 3'b000;
        sb_push("load_mm_stall", 1'b1, 2'b01, 64'h55, '0);
        tick();
        drain();

        // Two writers of r3: youngest wins, younger pending beats older ready
        issue(5'd3, 1'b1, 1'b0);
        tick();
        tick();
        hold();
        bus.stage_data[0] = 64'h11; bus.stage_data[1] = 64'h22; bus.stage_data[2] = 64'h33;
        bus.stage_ready = 3'b111; bus.rs[0] = 5'd3; bus.rs[1] = 5'd3;
        sb_push("youngest", 1'b0, 2'b11, 64'h11, 64'h11);
        tick();
        bus.stage_ready = 3'b110;
        sb_push("young_nready", 1'b1, 2'b00, '0, '0);
        tick();
        bus.advance = 1'b1;
        tick();
        bus.advance = 1'b0; bus.stage_ready = 3'b111;
        sb_push("mm_over_wb", 1'b0, 2'b11, 64'h22, 64'h22);
        tick();
        bus.advance = 1'b1;
        tick();
        bus.advance = 1'b0;
        sb_push("wb_fwd", 1'b0, 2'b11, 64'h33, 64'h33);
        tick();
        bus.advance = 1'b1;
        tick();
        bus.advance = 1'b0;
        sb_push("retired", 1'b0, 2'b11, 64'h55, 64'h66);
        tick();
        drain();

        // r0 and non-writing instructions are never tracked
        issue(5'd0, 1'b1, 1'b0);
        tick();
        hold();
        bus.rf_data[0] = '0; bus.stage_data[0] = 64'hDEAD; bus.stage_ready = 3'b000;
        sb_push("rd0", 1'b0, 2'b01, 64'h0, '0);
        tick();
        issue(5'd4, 1'b0, 1'b0);
        tick();
        hold();
        bus.rs[0] = 5'd4;
        sb_push("no_wr", 1'b0, 2'b01, 64'h0, '0);
        tick();
        bus.rf_data[0] = 64'h55;
        drain();

        // Flush while held kills EX entry
        issue(5'd9, 1'b1, 1'b0);
        tick();
        hold();
        bus.flush = 1'b1; bus.rs[0] = 5'd9; bus.stage_data[0] = 64'h99; bus.stage_ready = 3'b001;
        sb_push("pre_flush", 1'b0, 2'b01, 64'h99, '0);
        tick();
        bus.flush = 1'b0;
        sb_push("flushed", 1'b0, 2'b01, 64'h55, '0);
        tick();

        // Reset in the middle of a stall
        bus.rs[0] = '0;
        issue(5'd10, 1'b1, 1'b1);
        tick();
        hold();
        bus.rs[1] = 5'd10; bus.stage_ready = 3'b000;
        sb_push("pre_rst", 1'b1, 2'b01, 64'h55, '0);
        tick();
        rst_n = 1'b0;
        sb_push("rst_mid", 1'b0, 2'b11, 64'h55, 64'h66);
        tick();
        rst_n = 1'b1;
        sb_push("post_rst", 1'b0, 2'b11, 64'h55, 64'h66);
        tick();
        bus.rs[1] = '0;

`ifdef FWD_PERF_CNT_EN
        sb_push_cnt("cnt_zero", 1'b0, 32'd0);
        tick();
        issue(5'd11, 1'b1, 1'b1);
        tick();
        hold();
        bus.rs[0] = 5'd11; bus.stage_ready = 3'b000;
        repeat (4) tick();
        bus.stage_ready = 3'b001;
        sb_push_cnt("cnt_four", 1'b0, 32'd4);
        tick();
`endif

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) tick();
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the operand/result width.
REQ-002 Parameter REG_NUM, default 32, SHALL set the register count; tag width RW = $clog2(REG_NUM).
REQ-003 Parameter NUM_RD_PORTS, default 2, SHALL set the number of independent read/forward ports.
REQ-004 Parameter PIPE_DEPTH, default 3, SHALL set the number of tracked in-flight stages (0 = EX, 1 = MM, PIPE_DEPTH-1 = WB).
REQ-005 clk  input  1  SHALL be the single clock; all state on rising edge.
REQ-006 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 advance  input  1  SHALL be the pipeline-advance enable; tag table shifts only when 1.
REQ-008 flush  input  1  SHALL be the wrong-path kill of stage 0.
REQ-009 issue_valid, issue_wr_en, issue_is_load  input  1 each  SHALL describe the instruction leaving decode.
REQ-010 issue_rd  input  RW  SHALL be that instruction's destination register.
REQ-011 stage_data  input  PIPE_DEPTH x DATA_WIDTH  SHALL be the result presented by each stage.
REQ-012 stage_ready  input  PIPE_DEPTH  SHALL flag that stage_data[i] is final (load data returned).
REQ-013 rf_data  input  NUM_RD_PORTS x DATA_WIDTH  SHALL be the register-file read values.
REQ-014 rs  input  NUM_RD_PORTS x RW  SHALL be the source register per port.
REQ-015 fwd_data  output  NUM_RD_PORTS x DATA_WIDTH  SHALL be the forwarded operand per port.
REQ-016 stall  output  1  SHALL request decode hold on an unresolved hazard.

Function
REQ-017 Tag table SHALL hold PIPE_DEPTH entries {valid, rd, is_load}.
REQ-018 On advance=1: entry[i] <= entry[i-1] for i>=1; entry[0] <= {issue_valid & issue_wr_en & issue_rd!=0 & !stall & !flush, issue_rd, issue_is_load}.
REQ-019 On advance=0 the table SHALL hold, except flush=1 still clears entry[0].valid.
REQ-020 Per port, fwd_data SHALL combinationally select stage_data[i] of the lowest-index (youngest) valid entry with rd == rs; otherwise rf_data.
REQ-021 rs == 0 SHALL always return rf_data, never forward and never stall.
REQ-022 stall SHALL be 1 when any port's youngest match has stage_ready[i]=0; zero-cycle combinational path from rs/stage_ready.
REQ-023 An older ready match SHALL NOT be forwarded when a younger non-ready match exists (stall wins).
REQ-024 Simultaneous stall and advance: table shifts, entry[0] becomes a bubble (issue not captured).
REQ-025 Entry PIPE_DEPTH-1 retires on the next advance; same-cycle RF write/read is covered by forwarding from that entry.

Reset
REQ-026 rst_n=0 SHALL immediately clear all entry valid bits; stall = 0 and fwd_data = rf_data while reset is held.
REQ-027 Reset mid-hazard SHALL drop all pending hazards; the first cycle after release behaves as an empty table.

Configuration
REQ-028 With FWD_PERF_CNT_EN defined, output stall_cycles (32 bits) SHALL count cycles with stall=1, saturate at all-ones, reset to 0.
REQ-029 Without FWD_PERF_CNT_EN, the port and counter SHALL not exist.

Structure
REQ-030 Package fwd_pkg SHALL hold the tag-entry struct typedef and the stage-index constants (STG_EX=0, STG_MM=1).
REQ-031 Per-port priority select SHALL be sub-module fwd_port_sel, instantiated NUM_RD_PORTS times; the tag table stays in the top.

Verification
REQ-032 Issue rd=5 (ALU), advance; next cycle rs[0]=5, stage_data[0]=0xAA, stage_ready[0]=1 -> fwd_data[0]=0xAA, stall=0.
REQ-033 Issue rd=7 load, advance; rs[1]=7, stage_ready[0]=0 -> stall=1; advance with stage_ready[1]=1, stage_data[1]=0x1234 -> stall=0, fwd_data[1]=0x1234.
REQ-034 Entries 0 and 1 both rd=3 with data 0x11/0x22 -> fwd_data = 0x11 (youngest).
REQ-035 Issue rd=0 with issue_wr_en=1; rs=0, rf_data=0 -> fwd_data=0, stall=0, entry not valid.
REQ-036 flush with advance=0 on entry[0] rd=9 -> rs=9 returns rf_data; rst_n pulse mid-stall -> stall=0 at once.
REQ-037 With FWD_PERF_CNT_EN: hold a 4-cycle load stall -> stall_cycles=4.
